// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS-subset sequencer
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SW   = 2'b01;
    localparam logic [1:0] MW_SB   = 2'b11;
    localparam logic [1:0] MW_SH   = 2'b10;

    localparam logic [2:0] RW_NONE = 3'b000;
    localparam logic [2:0] RW_WORD = 3'b001;
    localparam logic [2:0] RW_SEXT = 3'b010;
    localparam logic [2:0] RW_ZEXT = 3'b100;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MDR  = 2'b01;
    localparam logic [1:0] M2R_LINK = 2'b10;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_J, CL_JAL, CL_JR, CL_JALR, CL_ILLEGAL
    } iclass_e;

    typedef enum logic [2:0] {BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ} br_kind_e;

    typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD} mem_width_e;

    typedef struct packed {
        iclass_e    cls;
        mem_width_e width;
        logic       sext;
        br_kind_e   br;
    } iclass_t;

    localparam iclass_t ICLASS_NONE = '{cls: CL_ILLEGAL, width: W_WORD, sext: 1'b0, br: BR_EQ};

    function automatic logic branch_taken(input br_kind_e kind, input logic zero, input logic sign);
        case (kind)
            BR_EQ:   return zero;
            BR_NE:   return ~zero;
            BR_LEZ:  return sign | zero;
            BR_GTZ:  return ~sign & ~zero;
            BR_LTZ:  return sign;
            BR_GEZ:  return ~sign;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] store_code(input mem_width_e width);
        case (width)
            W_BYTE:  return MW_SB;
            W_HALF:  return MW_SH;
            default: return MW_SW;
        endcase
    endfunction

    function automatic logic [2:0] load_code(input mem_width_e width, input logic sext);
        if (width == W_WORD) return RW_WORD;
        return sext ? RW_SEXT : RW_ZEXT;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_instr_class_decode.sv
// rtl/multicycle_ctrl_instr_class_decode.sv - combinational op/funct/rt to instruction class
module multicycle_ctrl_instr_class_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [4:0] rt_i,
    output iclass_t    ic_o
);

    // Only rt[0] distinguishes bltz from bgez; the rest of the field is a register number.
    logic rt_hi_unused;
    assign rt_hi_unused = ^rt_i[4:1];

    // Classify the held IR fields; anything not listed is illegal.
    always_comb begin
        ic_o = ICLASS_NONE;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    F_JR:   ic_o.cls = CL_JR;
                    F_JALR: ic_o.cls = CL_JALR;
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                    F_XOR, F_NOR, F_SLT, F_SLTU:
                            ic_o.cls = CL_ALU;
                    default: ic_o.cls = CL_ILLEGAL;
                endcase
            end
            OP_REGIMM: begin
                ic_o.cls = CL_BRANCH;
                ic_o.br  = rt_i[0] ? BR_GEZ : BR_LTZ;
            end
            OP_J:    ic_o.cls = CL_J;
            OP_JAL:  ic_o.cls = CL_JAL;
            OP_BEQ:  begin ic_o.cls = CL_BRANCH; ic_o.br = BR_EQ;  end
            OP_BNE:  begin ic_o.cls = CL_BRANCH; ic_o.br = BR_NE;  end
            OP_BLEZ: begin ic_o.cls = CL_BRANCH; ic_o.br = BR_LEZ; end
            OP_BGTZ: begin ic_o.cls = CL_BRANCH; ic_o.br = BR_GTZ; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                     ic_o.cls = CL_ALU;
            OP_LB:   begin ic_o.cls = CL_LOAD; ic_o.width = W_BYTE; ic_o.sext = 1'b1; end
            OP_LH:   begin ic_o.cls = CL_LOAD; ic_o.width = W_HALF; ic_o.sext = 1'b1; end
            OP_LW:   begin ic_o.cls = CL_LOAD; ic_o.width = W_WORD; end
            OP_LBU:  begin ic_o.cls = CL_LOAD; ic_o.width = W_BYTE; end
            OP_LHU:  begin ic_o.cls = CL_LOAD; ic_o.width = W_HALF; end
            OP_SB:   begin ic_o.cls = CL_STORE; ic_o.width = W_BYTE; end
            OP_SH:   begin ic_o.cls = CL_STORE; ic_o.width = W_HALF; end
            OP_SW:   begin ic_o.cls = CL_STORE; ic_o.width = W_WORD; end
            default: ic_o.cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle instruction sequencer with shared memory port
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ST_W  = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [4:0]       rt,
    input  logic             Zero,
    input  logic             Sign,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_ifetch,
    output logic [1:0]       MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       NPCOp,
    output logic [2:0]       RegWrite,
    output logic [1:0]       MemtoReg,
    output logic             illegal,
    output logic             retire,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e             state_q, state_d;
    iclass_t            cls_q, cls_d;
    iclass_t            dec_ic;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    multicycle_ctrl_instr_class_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .rt_i    (rt),
        .ic_o    (dec_ic)
    );

    // State, latched instruction class and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= ICLASS_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the class is captured leaving DECODE so later IR-bus changes are ignored.
    always_comb begin
        state_d = state_q;
        cls_d   = (state_q == ST_DECODE) ? dec_ic : cls_q;
        cnt_d   = cnt_q + CNT_W'(retire);
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (dec_ic.cls)
                    CL_J, CL_JR, CL_ILLEGAL: state_d = ST_FETCH;
                    CL_JAL, CL_JALR:         state_d = ST_WB;
                    default:                 state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls_q.cls)
                    CL_ALU:            state_d = ST_WB;
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_MEM: if (mem_ready) state_d = (cls_q.cls == CL_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-cycle strobes; DECODE uses the live decode, later states the latched class.
    always_comb begin
        mem_req    = 1'b0;
        mem_ifetch = 1'b0;
        MemWrite   = MW_NONE;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        NPCOp      = NPC_PC4;
        RegWrite   = RW_NONE;
        MemtoReg   = M2R_ALU;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            ST_DECODE: begin
                case (dec_ic.cls)
                    CL_J:       begin PCWrite = 1'b1; NPCOp = NPC_JUMP; retire = 1'b1; end
                    CL_JAL:     begin PCWrite = 1'b1; NPCOp = NPC_JUMP; end
                    CL_JR:      begin PCWrite = 1'b1; NPCOp = NPC_RS;   retire = 1'b1; end
                    CL_JALR:    begin PCWrite = 1'b1; NPCOp = NPC_RS;   end
                    CL_ILLEGAL: illegal = 1'b1;
                    default:    ;
                endcase
            end
            ST_EXEC: begin
                if (cls_q.cls == CL_BRANCH) begin
                    retire = 1'b1;
                    if (branch_taken(cls_q.br, Zero, Sign)) begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_BR;
                    end
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (cls_q.cls == CL_STORE) begin
                    MemWrite = store_code(cls_q.width);
                    retire   = mem_ready;
                end
            end
            ST_WB: begin
                retire = 1'b1;
                case (cls_q.cls)
                    CL_LOAD: begin
                        RegWrite = load_code(cls_q.width, cls_q.sext);
                        MemtoReg = M2R_MDR;
                    end
                    CL_JAL, CL_JALR: begin
                        RegWrite = RW_WORD;
                        MemtoReg = M2R_LINK;
                    end
                    default: RegWrite = RW_WORD;
                endcase
            end
            default: ;
        endcase
    end

    assign state       = ST_W'(state_q);
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and randomized checks of multicycle_ctrl against a phase-list model
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       op, funct;
    logic [4:0]       rt;
    logic             Zero, Sign, mem_ready;
    logic             mem_req, mem_ifetch, IRWrite, PCWrite, illegal, retire;
    logic [1:0]       MemWrite, NPCOp, MemtoReg;
    logic [2:0]       RegWrite;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired_cnt;

    multicycle_ctrl #(.ST_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .rt(rt),
        .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_ifetch(mem_ifetch), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .illegal(illegal), .retire(retire),
        .state(state), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [5:0] cur_op, cur_funct;
    logic [4:0] cur_rt;

    logic [17:0] obs;
    assign obs = {state, mem_req, mem_ifetch, MemWrite, IRWrite, PCWrite, NPCOp,
                  RegWrite, MemtoReg, illegal, retire};

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3;
    localparam int K_J = 4, K_JAL = 5, K_JR = 6, K_JALR = 7, K_ILL = 8;

    function automatic logic [17:0] ev(input int st, input bit req, input bit ifc,
                                       input logic [1:0] mw, input bit irw, input bit pcw,
                                       input logic [1:0] npc, input logic [2:0] rw,
                                       input logic [1:0] m2r, input bit ill, input bit ret);
        logic [2:0] s3;
        s3 = st[2:0];
        return {s3, req, ifc, mw, irw, pcw, npc, rw, m2r, ill, ret};
    endfunction

    // ISA view of the instruction: class, store code, load write-back code, branch kind.
    task automatic classify(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                            output int cls, output logic [1:0] mw, output logic [2:0] lrw,
                            output int brk);
        cls = K_ILL; mw = 2'b00; lrw = 3'b000; brk = 0;
        case (o)
            6'h00: case (f)
                6'h08: cls = K_JR;
                6'h09: cls = K_JALR;
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: cls = K_ALU;
                default: cls = K_ILL;
            endcase
            6'h01: begin cls = K_BRANCH; brk = r[0] ? 5 : 4; end
            6'h02: cls = K_J;
            6'h03: cls = K_JAL;
            6'h04, 6'h05, 6'h06, 6'h07: begin cls = K_BRANCH; brk = int'(o) - 4; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: cls = K_ALU;
            6'h20, 6'h21: begin cls = K_LOAD; lrw = 3'b010; end
            6'h23:        begin cls = K_LOAD; lrw = 3'b001; end
            6'h24, 6'h25: begin cls = K_LOAD; lrw = 3'b100; end
            6'h28: begin cls = K_STORE; mw = 2'b11; end
            6'h29: begin cls = K_STORE; mw = 2'b10; end
            6'h2B: begin cls = K_STORE; mw = 2'b01; end
            default: cls = K_ILL;
        endcase
    endtask

    // One clock: drive at the falling edge, compare 1 time unit later.
    task automatic step(input bit mr, input bit hold, input bit z, input bit s,
                        input string tag, input logic [17:0] expv);
        @(negedge clk);
        mem_ready = mr;
        Zero = z;
        Sign = s;
        if (hold) begin
            op = cur_op; funct = cur_funct; rt = cur_rt;
        end else begin
            op = 6'($urandom); funct = 6'($urandom); rt = 5'($urandom);
        end
        #1;
        checks++;
        assert (retired_cnt === CNT_W'(model_cnt)) else begin
            errors++;
            $error("FAIL %s/cnt: observed %0d expected %0d", tag, retired_cnt, CNT_W'(model_cnt));
        end
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        if (expv[0]) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                             input int fwait, input int mwait, input bit z, input bit s,
                             input string tag);
        int cls, brk;
        logic [1:0] mw;
        logic [2:0] lrw;
        bit taken;
        logic [17:0] d;
        classify(o, f, r, cls, mw, lrw, brk);
        for (int i = 0; i < fwait; i++)
            step(1'b0, 1'b0, rbit(), rbit(), {tag, "/fetchwait"}, ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cur_op = o; cur_funct = f; cur_rt = r;
        step(1'b1, 1'b1, rbit(), rbit(), {tag, "/fetch"}, ev(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        case (cls)
            K_J:    d = ev(2, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 1);
            K_JAL:  d = ev(2, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
            K_JR:   d = ev(2, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 1);
            K_JALR: d = ev(2, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0);
            K_ILL:  d = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            default: d = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endcase
        step(rbit(), 1'b1, rbit(), rbit(), {tag, "/decode"}, d);
        if (cls <= K_BRANCH) begin
            if (cls == K_BRANCH) begin
                case (brk)
                    0: taken = z;
                    1: taken = !z;
                    2: taken = s || z;
                    3: taken = !s && !z;
                    4: taken = s;
                    default: taken = !s;
                endcase
                d = ev(3, 0, 0, 0, 0, taken, taken ? 2'b01 : 2'b00, 0, 0, 0, 1);
            end else begin
                d = ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            step(rbit(), 1'b0, z, s, {tag, "/exec"}, d);
            if (cls == K_LOAD || cls == K_STORE) begin
                for (int i = 0; i < mwait; i++)
                    step(1'b0, 1'b0, rbit(), rbit(), {tag, "/memwait"},
                         ev(4, 1, 0, mw, 0, 0, 0, 0, 0, 0, 0));
                step(1'b1, 1'b0, rbit(), rbit(), {tag, "/mem"},
                     ev(4, 1, 0, mw, 0, 0, 0, 0, 0, 0, cls == K_STORE));
            end
            if (cls == K_ALU)
                step(rbit(), 1'b0, rbit(), rbit(), {tag, "/wb"}, ev(5, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 0, 1));
            if (cls == K_LOAD)
                step(rbit(), 1'b0, rbit(), rbit(), {tag, "/wb"}, ev(5, 0, 0, 0, 0, 0, 0, lrw, 2'b01, 0, 1));
        end
        if (cls == K_JAL || cls == K_JALR)
            step(rbit(), 1'b0, rbit(), rbit(), {tag, "/wb"}, ev(5, 0, 0, 0, 0, 0, 0, 3'b001, 2'b10, 0, 1));
    endtask

    logic [5:0] op_tbl [28] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
                                6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h10};
    logic [5:0] fn_tbl [22] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F,
                                6'h08, 6'h09};

    initial begin
        rst = 1'b1; mem_ready = 1'b0; Zero = 1'b0; Sign = 1'b0;
        op = '0; funct = '0; rt = '0;
        cur_op = '0; cur_funct = '0; cur_rt = '0;
        repeat (3) @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b0, "reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        run_instr(6'h00, 6'h21, 5'd0, 0, 0, 0, 0, "addu");
        run_instr(6'h23, 6'h00, 5'd0, 1, 3, 0, 0, "lw");
        run_instr(6'h04, 6'h00, 5'd0, 0, 0, 1, 0, "beq_taken");
        run_instr(6'h04, 6'h00, 5'd0, 0, 0, 0, 0, "beq_nottaken");
        run_instr(6'h03, 6'h00, 5'd0, 0, 0, 0, 0, "jal");
        run_instr(6'h28, 6'h00, 5'd0, 2, 1, 0, 0, "sb");
        run_instr(6'h3F, 6'h00, 5'd0, 0, 0, 0, 0, "illegal");
        run_instr(6'h01, 6'h00, 5'd1, 0, 0, 0, 1, "bgez_neg");
        run_instr(6'h00, 6'h09, 5'd0, 0, 0, 0, 0, "jalr");

        // Reset while a load is waiting in MEM with its request raised.
        cur_op = 6'h23; cur_funct = 6'h00; cur_rt = 5'd0;
        step(1'b1, 1'b1, 1'b0, 1'b0, "rstmem/fetch", ev(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0, "rstmem/decode", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b0, "rstmem/exec", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b0, "rstmem/mem", ev(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        model_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, "rstmem/after", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        run_instr(6'h2B, 6'h00, 5'd0, 0, 0, 0, 0, "sw_after_rst");

        for (int n = 0; n < 150; n++) begin
            logic [5:0] o, f;
            o = op_tbl[$urandom_range(0, 27)];
            f = fn_tbl[$urandom_range(0, 21)];
            run_instr(o, f, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      rbit(), rbit(), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
